// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// valid/ready requesters, one operation in flight at a time.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [5:0]           req_f,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_y,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_f,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_zero,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  localparam logic [2:0] F_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_f;

  // Round-robin pick: on contention, favour the requester not served last.
  always_comb begin
    sel = 1'b0;
    if (&req_valid) begin
      sel = ~last_grant;
    end else if (req_valid[1]) begin
      sel = 1'b1;
    end
  end

  assign req_ready = (state == IDLE && req_valid != 2'b00)
                     ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  // ALU sees only captured operands, never live request inputs.
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_f = op_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_f       <= '0;
      rsp_y      <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            op_a  <= sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            op_b  <= sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            op_f  <= sel ? req_f[5:3] : req_f[2:0];
            grant <= sel;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_f == F_ILLEGAL) begin
            rsp_y    <= '0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            ops_done   <= ops_done + CNT_W'(1);
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready, req_ready2;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_f;
  logic [1:0]  rsp_valid, rsp_valid2;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_y, rsp_y2;
  logic        rsp_zero, rsp_zero2, rsp_err, rsp_err2;
  logic [31:0] alu_a, alu_b, alu_y, alu_a2, alu_b2, alu_y2;
  logic [2:0]  alu_f, alu_f2;
  logic        alu_zero, alu_zero2;
  logic        busy, busy2;
  logic [15:0] ops_done;
  logic [1:0]  ops_done2;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
    logic [31:0] y;
    case (f)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a + b;
      3'b100:  y = a & ~b;
      3'b101:  y = a | ~b;
      3'b110:  y = a - b;
      3'b111:  y = {31'd0, ($signed(a) < $signed(b))};
      default: y = 32'hDEAD_BEEF;
    endcase
    return {(y == 32'd0), y};
  endfunction

  assign {alu_zero, alu_y}   = alu_model(alu_a, alu_b, alu_f);
  assign {alu_zero2, alu_y2} = alu_model(alu_a2, alu_b2, alu_f2);

  alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_f(req_f), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  alu_share_arbiter #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_f(req_f), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y2), .rsp_zero(rsp_zero2), .rsp_err(rsp_err2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_f(alu_f2), .alu_y(alu_y2), .alu_zero(alu_zero2),
    .busy(busy2), .ops_done(ops_done2)
  );

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ops = 0;
  endtask

  // One transaction on requester idx with hand-computed expectations.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [31:0] ey, input logic ez,
                        input logic ee);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_f[idx*3 +: 3]   = f;
    req_valid = oh;
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (req_ready !== oh) begin
      errors++; $display("FAIL op_req_ready: got %b want %b", req_ready, oh);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_a = ~req_a;
    req_b = ~req_b;
    checks++;
    if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL op_exec: busy=%b req_ready=%b rsp_valid=%b want 1 00 00",
                         busy, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== oh || rsp_y !== ey || rsp_zero !== ez || rsp_err !== ee) begin
      errors++; $display("FAIL op_resp: valid=%b y=%h z=%b e=%b want %b %h %b %b",
                         rsp_valid, rsp_y, rsp_zero, rsp_err, oh, ey, ez, ee);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    exp_ops++;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== 16'(exp_ops)) begin
      errors++; $display("FAIL op_done: valid=%b busy=%b ops=%0d want 00 0 %0d",
                         rsp_valid, busy, ops_done, exp_ops);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== 16'd0 ||
        rsp_y !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0 || alu_a !== 32'd0 ||
        alu_f !== 3'd0) begin
      errors++; $display("FAIL reset_state: rr=%b rv=%b busy=%b ops=%0d y=%h alu_a=%h",
                         req_ready, rsp_valid, busy, ops_done, rsp_y, alu_a);
    end
  endtask

  task automatic test_basic();
    run_op(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0);
    run_op(1, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1, 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    run_op(1, 32'h0000_00F0, 32'h0000_00FF, 3'b100, 32'd0, 1'b1, 1'b0);
    run_op(0, 32'd0, 32'hFFFF_FFFE, 3'b101, 32'd1, 1'b0, 1'b0);
  endtask

  task automatic test_fairness();
    logic [1:0] oh;
    apply_reset();
    req_a = {32'd10, 32'd10};
    req_b = {32'd3, 32'd3};
    req_f = {3'b110, 3'b010};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== oh) begin
        errors++; $display("FAIL fair_grant%0d: got %b want %b", i, req_ready, oh);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b00) begin
        errors++; $display("FAIL fair_exec%0d: rsp_valid=%b want 00", i, rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== oh || rsp_y !== ((i % 2 == 0) ? 32'd13 : 32'd7)) begin
        errors++; $display("FAIL fair_resp%0d: valid=%b y=%0d want %b %0d", i, rsp_valid,
                           rsp_y, oh, (i % 2 == 0) ? 13 : 7);
      end
      @(posedge clk);
    end
    #1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    exp_ops = 4;
    checks++;
    if (ops_done !== 16'd4) begin
      errors++; $display("FAIL fair_count: ops_done=%0d want 4", ops_done);
    end
  endtask

  task automatic test_stall();
    req_a[63:32] = 32'd2;
    req_b[63:32] = 32'd3;
    req_f[5:3]   = 3'b000;
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 2'b10 || rsp_y !== 32'd2 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL stall%0d: valid=%b y=%0d rr=%b busy=%b want 10 2 00 1",
                           i, rsp_valid, rsp_y, req_ready, busy);
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    exp_ops++;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || ops_done !== 16'(exp_ops)) begin
      errors++; $display("FAIL stall_release: busy=%b valid=%b ops=%0d want 0 00 %0d",
                         busy, rsp_valid, ops_done, exp_ops);
    end
  endtask

  task automatic test_illegal();
    run_op(0, 32'd3, 32'd4, 3'b011, 32'd0, 1'b1, 1'b1);
    run_op(1, 32'd3, 32'd4, 3'b001, 32'd7, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_and_midreset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(i % 2, 32'(i), 32'd1, 3'b010, 32'(i + 1), 1'b0, 1'b0);
    end
    checks++;
    if (ops_done2 !== 2'd1) begin
      errors++; $display("FAIL wrap_cnt2: ops_done=%0d want 1", ops_done2);
    end
    req_a[31:0] = 32'd8;
    req_b[31:0] = 32'd8;
    req_f[2:0]  = 3'b010;
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== 16'd0 || ops_done2 !== 2'd0) begin
        errors++; $display("FAIL midreset%0d: valid=%b busy=%b ops=%0d ops2=%0d want 00 0 0 0",
                           i, rsp_valid, busy, ops_done, ops_done2);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_f = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_fairness();
    test_stall();
    test_illegal();
    test_wrap_and_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (ports a, b, f, y, zero) between two requesters.
- Each requester uses a valid/ready handshake for requests and for responses.
- Arbitration is round-robin, one operation in flight at a time.
- The block registers operands, drives the ALU, captures the result and holds it until the granted requester accepts it.
- Sits between the ALU instance and its clients, for example a control FSM and a debug/test port.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  2  bit i: requester i presents an operation.
req_ready  output  2  bit i: block accepts requester i's operation this cycle.
req_a  input  2*WIDTH  operand A; requester i in [i*WIDTH +: WIDTH].
req_b  input  2*WIDTH  operand B; same packing.
req_f  input  6  ALU function; requester i in [i*3 +: 3].
rsp_valid  output  2  one-hot; bit i: result pending for requester i.
rsp_ready  input  2  bit i: requester i takes the result.
rsp_y  output  WIDTH  result, shared; meaningful only while rsp_valid != 0.
rsp_zero  output  1  zero flag of the result.
rsp_err  output  1  1 when the request used the illegal function 3'b011.
alu_a  output  WIDTH  to ALU a.
alu_b  output  WIDTH  to ALU b.
alu_f  output  3  to ALU f.
alu_y  input  WIDTH  from ALU y.
alu_zero  input  1  from ALU zero.
busy  output  1  high in EXEC or RESP.
ops_done  output  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to IDLE. last_grant = 1, so requester 0 wins first.
  - The following clear to 0: op_a, op_b, op_f, grant, rsp_y, rsp_zero, rsp_err, ops_done.
  - All outputs read 0 after reset: req_ready = 0, rsp_valid = 0, busy = 0.
- ALU drive: alu_a/alu_b/alu_f come from op_a/op_b/op_f registers at all times, never directly from req_* inputs.
- Function encoding: 000 AND, 001 OR, 010 ADD, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT (signed); 011 is illegal.
- IDLE:
  - req_ready is combinational and one-hot to the selected requester only.
  - Selection: if only one req_valid is set, grant it. If both are set, grant the one not equal to last_grant.
  - On req_valid & req_ready: capture a, b, f and grant; go to EXEC.
  - If no request is valid: stay in IDLE with req_ready = 0.
- EXEC (exactly 1 cycle; req_ready = 0):
  - Legal f: rsp_y <= alu_y, rsp_zero <= alu_zero, rsp_err <= 0.
  - f = 011: rsp_y <= 0, rsp_zero <= 1, rsp_err <= 1.
  - Go to RESP.
- RESP:
  - rsp_valid[grant] = 1; req_ready = 0.
  - rsp_y/zero/err stay stable until handshake.
  - On rsp_ready[grant]: ops_done += 1 (wraps), last_grant <= grant, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency and throughput:
  - Accept at edge T, EXEC in cycle T+1, rsp_valid from cycle T+2.
  - With rsp_ready held high, throughput is one operation per 3 cycles.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1,...
- Request changes: a requester may drop req_valid before acceptance; no state changes. Operands changing after acceptance do not affect the result.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, ops_done is not incremented.

Test Plan:
- Reset, then req0: a=5, b=7, f=010 -> req_ready[0] for 1 cycle; rsp_valid=01 two cycles later; rsp_y=12, rsp_zero=0, rsp_err=0; ops_done=1.
- req1: a=9, b=9, f=110 -> rsp_valid=10, rsp_y=0, rsp_zero=1. Then req0: a=32'hFFFFFFFF, b=1, f=111 -> rsp_y=1, zero=0.
- Both req_valid held with distinct ops, rsp_ready=11, 4 transactions -> grant order 0,1,0,1; ops_done=4; never both rsp_valid bits set.
- rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_y constant; req_ready=00 throughout; busy=1. Raise rsp_ready -> IDLE next cycle.
- req0 with f=011, a=3, b=4 -> rsp_err=1, rsp_y=0, rsp_zero=1; ops_done increments.
- CNT_W=2: complete 5 ops -> ops_done reads 1. Assert reset during EXEC -> rsp_valid never asserts; ops_done=0, state IDLE.
